// File: rtl/cpu_debug_ocimem_ctrl.sv
// OCIMEM access controller: turns debug-slave command pulses into debug RAM reads and writes.
// Optional byte parity on the RAM data port is enabled by defining OCIMEM_BYTE_PARITY_EN.
module cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
`ifdef OCIMEM_BYTE_PARITY_EN
  output logic [35:0]       ram_wdata,
  input  logic [35:0]       ram_rdata,
`else
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
`endif
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

`ifdef OCIMEM_BYTE_PARITY_EN
  localparam int RAM_W = 36;
`else
  localparam int RAM_W = 32;
`endif

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RD_ISSUE = 2'd1;
  localparam logic [1:0] S_RD_CAPT  = 2'd2;
  localparam logic [1:0] S_WR       = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_mon_d;
  logic              r_err;
  logic [RAM_W-1:0]  r_wdata;

  logic w_idle;
  logic w_cmd_a;
  logic w_cmd_n;
  logic w_cmd_b;
  logic w_any;
  logic w_collide;
  logic w_par_err;
  logic w_err_set;
  logic w_err_clr;
  logic w_unused;

  // Even parity per byte: bit i is the XOR of byte i, so each 9-bit group has even weight.
  function automatic logic [3:0] par_gen(input logic [31:0] d);
    par_gen = {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
  endfunction

  // Fixed priority b > a > no_action; lower pulses in the same cycle are dropped.
  assign w_idle    = (r_state == S_IDLE);
  assign w_cmd_b   = take_action_ocimem_b;
  assign w_cmd_a   = take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_cmd_n   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_any     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_collide = (take_action_ocimem_a & take_action_ocimem_b) |
                     (take_action_ocimem_a & take_no_action_ocimem_a) |
                     (take_action_ocimem_b & take_no_action_ocimem_a);

`ifdef OCIMEM_BYTE_PARITY_EN
  assign w_par_err = (r_state == S_RD_CAPT) && (ram_rdata[35:32] != par_gen(ram_rdata[31:0]));
  assign w_unused  = ^{jdo[37], jdo[35], jdo[2:0]};
`else
  assign w_par_err = 1'b0;
  assign w_unused  = ^{jdo[37], jdo[35], jdo[2:0], par_gen(32'd0)};
`endif

  assign w_err_set = (w_any & ~w_idle) | (w_collide & w_idle) | w_par_err;
  assign w_err_clr = w_idle & w_cmd_a & jdo[36];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mon_a <= '0;
      r_mon_d <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_b) begin
            r_state <= S_WR;
          end else if (w_cmd_a) begin
            r_mon_a <= jdo[ADDR_W+16:17];
            if (jdo[34]) r_state <= S_RD_ISSUE;
          end else if (w_cmd_n) begin
            r_state <= S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: r_state <= S_RD_CAPT;
        S_RD_CAPT: begin
          r_mon_d <= ram_rdata[31:0];
          r_mon_a <= r_mon_a + 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_mon_a <= r_mon_a + 1'b1;
          r_state <= S_IDLE;
        end
      endcase
      // A new error in the same cycle as a clear request wins.
      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
    end
  end

  // Write data is pure datapath; it only matters while ram_we is high.
  always_ff @(posedge clk) begin
    if (w_idle & w_cmd_b) begin
`ifdef OCIMEM_BYTE_PARITY_EN
      r_wdata <= {par_gen(jdo[34:3]), jdo[34:3]};
`else
      r_wdata <= jdo[34:3];
`endif
    end
  end

  assign ram_addr      = r_mon_a;
  assign ram_re        = (r_state == S_RD_ISSUE);
  assign ram_we        = (r_state == S_WR);
  assign ram_wdata     = r_wdata;
  assign MonDReg       = r_mon_d;
  assign monitor_ready = w_idle;
  assign monitor_error = r_err;

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Directed bench for cpu_debug_ocimem_ctrl with a synchronous 256-word RAM model.
// Build with OCIMEM_BYTE_PARITY_EN defined to exercise the parity path.
module tb_cpu_debug_ocimem_ctrl;
`ifdef OCIMEM_BYTE_PARITY_EN
  localparam int DW = 36;
`else
  localparam int DW = 32;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          ta, tn, tb;
  logic [7:0]    ram_addr;
  logic          ram_re, ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;

  logic [DW-1:0] mem [256];
  logic          mem_init, corrupt;
  logic [7:0]    corrupt_a;
  int            we_cnt = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  cpu_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tn), .take_action_ocimem_b(tb),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  function automatic logic [DW-1:0] mkw(input logic [31:0] d);
    mkw = '0;
    mkw[31:0] = d;
`ifdef OCIMEM_BYTE_PARITY_EN
    mkw[35:32] = {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
`endif
  endfunction

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
    jdo_a = '0;
    jdo_a[24:17] = a;
    jdo_a[34] = rd;
    jdo_a[36] = clr;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    jdo_b = '0;
    jdo_b[34:3] = d;
  endfunction

  // RAM model: read data appears one cycle after ram_re.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = mkw(32'hA500_0000 | i);
      ram_rdata <= '0;
    end else begin
`ifdef OCIMEM_BYTE_PARITY_EN
      if (corrupt) mem[corrupt_a][34] = ~mem[corrupt_a][34];
`endif
      if (ram_we) begin
        mem[ram_addr] = ram_wdata;
        we_cnt++;
      end
      if (ram_re) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; jdo = '0; ta = 1'b0; tn = 1'b0; tb = 1'b0;
    mem_init = 1'b1; corrupt = 1'b0; corrupt_a = '0;
    repeat (3) tick();
    mem_init = 1'b0;
    check("rst_ready", monitor_ready, 1);
    check("rst_err",   monitor_error, 0);
    check("rst_dreg",  MonDReg, 0);
    check("rst_re",    ram_re, 0);
    check("rst_we",    ram_we, 0);
    check("rst_addr",  ram_addr, 0);
    reset = 1'b0;
    tick();

    // Address load only.
    jdo = jdo_a(8'h10, 1'b0, 1'b0); ta = 1'b1; tick(); ta = 1'b0;
    check("ld_ready", monitor_ready, 1);
    check("ld_re",    ram_re, 0);
    check("ld_addr",  ram_addr, 8'h10);
    tick();
    check("ld_re2",   ram_re, 0);

    // Write 0xDEADBEEF at 0x10.
    jdo = jdo_b(32'hDEAD_BEEF); tb = 1'b1; tick(); tb = 1'b0;
    check("wr_we",    ram_we, 1);
    check("wr_addr",  ram_addr, 8'h10);
    check("wr_data",  ram_wdata, mkw(32'hDEAD_BEEF));
    check("wr_ready", monitor_ready, 0);
    tick();
    check("wr_we_off", ram_we, 0);
    check("wr_inc",    ram_addr, 8'h11);
    check("wr_mem",    mem[8'h10], mkw(32'hDEAD_BEEF));

    // no_action_a reads at 0x11.
    tn = 1'b1; tick(); tn = 1'b0;
    check("rd_re",    ram_re, 1);
    check("rd_addr",  ram_addr, 8'h11);
    check("rd_ready", monitor_ready, 0);
    tick();
    check("rd_capt_ready", monitor_ready, 0);
    check("rd_capt_re",    ram_re, 0);
    tick();
    check("rd_dreg",  MonDReg, 32'hA500_0011);
    check("rd_inc",   ram_addr, 8'h12);
    check("rd_err",   monitor_error, 0);

    // action_a with read flag.
    jdo = jdo_a(8'h10, 1'b1, 1'b0); ta = 1'b1; tick(); ta = 1'b0;
    check("ar_ready0", monitor_ready, 0);
    check("ar_re",     ram_re, 1);
    check("ar_addr",   ram_addr, 8'h10);
    tick();
    check("ar_ready1", monitor_ready, 0);
    check("ar_dreg_old", MonDReg, 32'hA500_0011);
    tick();
    check("ar_dreg",  MonDReg, 32'hDEAD_BEEF);
    check("ar_inc",   ram_addr, 8'h11);
    check("ar_ready2", monitor_ready, 1);
    check("ar_err",   monitor_error, 0);

    // Wrap at 0xFF.
    jdo = jdo_a(8'hFF, 1'b0, 1'b0); ta = 1'b1; tick(); ta = 1'b0;
    check("wrap_ld", ram_addr, 8'hFF);
    jdo = jdo_b(32'h1234_5678); tb = 1'b1; tick(); tb = 1'b0;
    check("wrap_we",   ram_we, 1);
    check("wrap_addr", ram_addr, 8'hFF);
    tick();
    check("wrap_inc", ram_addr, 8'h00);
    check("wrap_mem", mem[8'hFF], mkw(32'h1234_5678));

    // Read at 0x00 with a stray pulse during capture.
    tn = 1'b1; tick(); tn = 1'b0;
    check("busy_re",   ram_re, 1);
    check("busy_addr", ram_addr, 8'h00);
    tick();
    tn = 1'b1; tick(); tn = 1'b0;
    check("busy_dreg",  MonDReg, 32'hA500_0000);
    check("busy_err",   monitor_error, 1);
    check("busy_addr2", ram_addr, 8'h01);
    check("busy_ready", monitor_ready, 1);
    check("busy_re2",   ram_re, 0);
    tick();
    check("busy_drop", ram_re, 0);

    // Clear error with jdo[36].
    jdo = jdo_a(8'h20, 1'b0, 1'b1); ta = 1'b1; tick(); ta = 1'b0;
    check("clr_err",  monitor_error, 0);
    check("clr_addr", ram_addr, 8'h20);

    // Write and read collide: write wins.
    jdo = jdo_b(32'hCAFE_F00D); tb = 1'b1; tn = 1'b1; tick(); tb = 1'b0; tn = 1'b0;
    check("col_we",   ram_we, 1);
    check("col_re",   ram_re, 0);
    check("col_err",  monitor_error, 1);
    check("col_addr", ram_addr, 8'h20);
    tick();
    check("col_mem",  mem[8'h20], mkw(32'hCAFE_F00D));
    check("col_re2",  ram_re, 0);
    check("col_inc",  ram_addr, 8'h21);

    // Reset in the middle of a write.
    jdo = jdo_b(32'h0BAD_C0DE); tb = 1'b1; tick(); tb = 1'b0;
    check("rw_we", ram_we, 1);
    reset = 1'b1;
    #1;
    check("rw_we_off", ram_we, 0);
    check("rw_re",     ram_re, 0);
    check("rw_ready",  monitor_ready, 1);
    check("rw_dreg",   MonDReg, 0);
    check("rw_err",    monitor_error, 0);
    check("rw_addr",   ram_addr, 0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check("rw_we_cnt", we_cnt, 3);
    check("rw_mem",    mem[8'h21], mkw(32'hA500_0021));
    check("rw_we2",    ram_we, 0);

`ifdef OCIMEM_BYTE_PARITY_EN
    // Corrupt byte-2 parity of word 0x30, then read it.
    corrupt_a = 8'h30; corrupt = 1'b1; tick(); corrupt = 1'b0;
    jdo = jdo_a(8'h30, 1'b1, 1'b1); ta = 1'b1; tick(); ta = 1'b0;
    check("par_err0", monitor_error, 0);
    tick(); tick();
    check("par_err",  monitor_error, 1);
    check("par_dreg", MonDReg, 32'hA500_0030);
    check("par_addr", ram_addr, 8'h31);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
